baz_det_sched: RTL and testbench

//  Round-robin scheduler that shares one keyword detector (e.g. "BAZ") between NUM_SRC

---
 rtl/baz_det_sched_if.sv | 32 +++
 rtl/baz_det_sched.sv | 213 +++++++++++++++++++++
 tb/tb_baz_det_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/baz_det_sched_if.sv
// Bundle of character-source, detector and result signals shared between the
// keyword scheduler and its surroundings. The scheduler uses the slave view;
// whatever drives the sources and the detector uses the master view.
interface baz_det_sched_if #(
    parameter int NUM_SRC = 4
);
    logic [NUM_SRC-1:0]   req_valid;
    logic [8*NUM_SRC-1:0] req_char;
    logic [NUM_SRC-1:0]   req_last;
    logic [NUM_SRC-1:0]   req_ready;
    logic [7:0]           det_char;
    logic                 det_valid;
    logic                 det_clr;
    logic                 det_match;
    logic [NUM_SRC-1:0]   resp_valid;
    logic                 resp_match;
    logic                 resp_abort;
    logic [2:0]           grant_id;
    logic                 busy;

    modport master (
        output req_valid, req_char, req_last, det_match,
        input  req_ready, det_char, det_valid, det_clr,
               resp_valid, resp_match, resp_abort, grant_id, busy
    );

    modport slave (
        input  req_valid, req_char, req_last, det_match,
        output req_ready, det_char, det_valid, det_clr,
               resp_valid, resp_match, resp_abort, grant_id, busy
    );
endinterface

// File: rtl/baz_det_sched.sv
// Round-robin scheduler sharing one keyword detector between NUM_SRC character
// sources. One source owns the detector for a whole word; its characters are
// forwarded one per cycle, the (sticky) match flag is collected, the result is
// strobed back to that source and the detector is flushed before the next word.
// Note: rstn is an active-HIGH asynchronous reset despite its name.
module baz_det_sched #(
    parameter int NUM_SRC = 4,
    parameter int DET_LAT = 2,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rstn,
    baz_det_sched_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GRANT  = 3'd1,
        ST_STREAM = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RESP   = 3'd4,
        ST_FLUSH  = 3'd5
    } state_t;

    localparam logic [7:0] DET_LAT_C  = 8'(DET_LAT);
    localparam logic [7:0] TO_LAST_C  = 8'(TIMEOUT - 1);
    localparam logic [2:0] LAST_SRC_C = 3'(NUM_SRC - 1);

    state_t               state_q, state_d;
    logic [2:0]           rr_q, rr_d;
    logic [2:0]           win_q, win_d;
    logic [2:0]           grant_q, grant_d;
    logic [7:0]           to_cnt_q, to_cnt_d;
    logic [7:0]           wait_cnt_q, wait_cnt_d;
    logic                 match_q, match_d;
    logic [7:0]           det_char_q, det_char_d;
    logic                 det_valid_q, det_valid_d;
    logic                 det_clr_q, det_clr_d;
    logic [NUM_SRC-1:0]   resp_valid_q, resp_valid_d;
    logic                 resp_match_q, resp_match_d;
    logic                 resp_abort_q, resp_abort_d;
    logic                 busy_q, busy_d;

    logic [NUM_SRC-1:0]   gnt_oh_s;
    logic [7:0]           sel_char_s;
    logic                 sel_last_s;
    logic                 sel_valid_s;
    logic                 hs_s;
    logic [2:0]           rr_win_s;
    logic                 take_s;
    int                   dist_s;
    int                   best_dist_s;

    // Round-robin pick: the requester with the smallest distance at/after rr_q wins.
    always_comb begin
        best_dist_s = NUM_SRC;
        dist_s      = 0;
        take_s      = 1'b0;
        rr_win_s    = 3'd0;
        for (int i = 0; i < NUM_SRC; i++) begin
            dist_s      = (i >= int'(rr_q)) ? (i - int'(rr_q)) : (i + NUM_SRC - int'(rr_q));
            take_s      = bus.req_valid[i] && (dist_s < best_dist_s);
            best_dist_s = take_s ? dist_s : best_dist_s;
            rr_win_s    = take_s ? 3'(i) : rr_win_s;
        end
    end

    // Decode the granted source and route its character/last/valid lines.
    always_comb begin
        gnt_oh_s    = {NUM_SRC{1'b0}};
        sel_char_s  = 8'd0;
        sel_last_s  = 1'b0;
        sel_valid_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == 3'(i)) begin
                gnt_oh_s[i] = 1'b1;
                sel_char_s  = bus.req_char[8*i +: 8];
                sel_last_s  = bus.req_last[i];
                sel_valid_s = bus.req_valid[i];
            end else begin
                gnt_oh_s[i] = 1'b0;
            end
        end
    end

    // Only the granted source sees ready, and only while streaming.
    assign hs_s          = (state_q == ST_STREAM) && sel_valid_s;
    assign bus.req_ready = (state_q == ST_STREAM) ? (gnt_oh_s & bus.req_valid) : {NUM_SRC{1'b0}};

    // Next-state and next-output logic for the word scheduling FSM.
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        win_d        = win_q;
        grant_d      = grant_q;
        to_cnt_d     = 8'd0;
        wait_cnt_d   = 8'd0;
        match_d      = match_q;
        det_char_d   = det_char_q;
        det_valid_d  = 1'b0;
        det_clr_d    = 1'b0;
        resp_valid_d = {NUM_SRC{1'b0}};
        resp_match_d = 1'b0;
        resp_abort_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|bus.req_valid) begin
                    state_d = ST_GRANT;
                    win_d   = rr_win_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                grant_d = win_q;
                rr_d    = (win_q == LAST_SRC_C) ? 3'd0 : (win_q + 3'd1);
                match_d = 1'b0;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                match_d = match_q | bus.det_match;
                if (hs_s) begin
                    det_valid_d = 1'b1;
                    det_char_d  = sel_char_s;
                    to_cnt_d    = 8'd0;
                    if (sel_last_s) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end else if (to_cnt_q == TO_LAST_C) begin
                    // Source went silent too long: report an aborted word.
                    state_d      = ST_RESP;
                    resp_valid_d = gnt_oh_s;
                    resp_abort_d = 1'b1;
                    resp_match_d = 1'b0;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                    state_d  = ST_STREAM;
                end
            end
            ST_WAIT: begin
                match_d = match_q | bus.det_match;
                if (wait_cnt_q == DET_LAT_C) begin
                    state_d      = ST_RESP;
                    resp_valid_d = gnt_oh_s;
                    resp_match_d = match_q | bus.det_match;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    state_d    = ST_WAIT;
                end
            end
            ST_RESP: begin
                det_clr_d = 1'b1;
                state_d   = ST_FLUSH;
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered-output update; rstn clears everything at once.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q      <= ST_IDLE;
            rr_q         <= 3'd0;
            win_q        <= 3'd0;
            grant_q      <= 3'd0;
            to_cnt_q     <= 8'd0;
            wait_cnt_q   <= 8'd0;
            match_q      <= 1'b0;
            det_char_q   <= 8'd0;
            det_valid_q  <= 1'b0;
            det_clr_q    <= 1'b0;
            resp_valid_q <= {NUM_SRC{1'b0}};
            resp_match_q <= 1'b0;
            resp_abort_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            win_q        <= win_d;
            grant_q      <= grant_d;
            to_cnt_q     <= to_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            match_q      <= match_d;
            det_char_q   <= det_char_d;
            det_valid_q  <= det_valid_d;
            det_clr_q    <= det_clr_d;
            resp_valid_q <= resp_valid_d;
            resp_match_q <= resp_match_d;
            resp_abort_q <= resp_abort_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.det_char   = det_char_q;
    assign bus.det_valid  = det_valid_q;
    assign bus.det_clr    = det_clr_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_match = resp_match_q;
    assign bus.resp_abort = resp_abort_q;
    assign bus.grant_id   = grant_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_baz_det_sched.sv
// Testbench for baz_det_sched: directed scenarios followed by random rounds of
// words from random subsets of sources. Expected responses are derived from the
// words themselves (keyword search, abort flag, forwarded characters, latency)
// and checked by an independent monitor whenever a response strobe appears.
module tb_baz_det_sched;

    localparam int NUM_SRC = 4;
    localparam int DET_LAT = 2;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    baz_det_sched_if #(.NUM_SRC(NUM_SRC)) bif ();

    baz_det_sched #(
        .NUM_SRC(NUM_SRC),
        .DET_LAT(DET_LAT),
        .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Keyword detector model: flags "BAZ" DET_LAT cycles after the 'Z' arrives, sticky until cleared.
    logic [7:0]         hist1, hist2;
    logic [DET_LAT-1:0] pipe;
    logic               lvl;

    always @(posedge clk or posedge rstn) begin
        if (rstn) begin
            hist1 <= 8'd0; hist2 <= 8'd0; pipe <= '0; lvl <= 1'b0;
        end else if (bif.det_clr) begin
            hist1 <= 8'd0; hist2 <= 8'd0; pipe <= '0; lvl <= 1'b0;
        end else begin
            pipe <= {pipe[DET_LAT-2:0],
                     bif.det_valid && hist2 == 8'h42 && hist1 == 8'h41 && bif.det_char == 8'h5A};
            lvl  <= lvl | pipe[DET_LAT-1];
            if (bif.det_valid) begin
                hist2 <= hist1;
                hist1 <= bif.det_char;
            end
        end
    end

    assign bif.det_match = lvl | pipe[DET_LAT-1];

    // Scoreboard: one entry per issued word
    int    exp_src[$];
    bit    exp_m[$];
    bit    exp_a[$];
    string exp_s[$];
    int    exp_order[$];

    // Driver plan
    string word[NUM_SRC];
    int    abort_k[NUM_SRC];
    int    gap_max;

    function automatic bit has_baz(input string s);
        for (int j = 0; j + 3 <= s.len(); j++)
            if (s.substr(j, j + 2) == "BAZ") return 1'b1;
        return 1'b0;
    endfunction

    function automatic string rand_word();
        string alph = "BAZNK";
        string s = "";
        int n;
        int p;
        n = $urandom_range(1, 5);
        for (int j = 0; j < n; j++) s = $sformatf("%s%c", s, alph[$urandom_range(0, 4)]);
        if ($urandom_range(0, 2) == 0) begin
            p = $urandom_range(0, n);
            s = {s.substr(0, p - 1), "BAZ", s.substr(p, s.len() - 1)};
        end
        return s;
    endfunction

    // k < 0: complete word; k >= 1: send k characters without 'last', then go silent.
    task automatic issue(input int src, input string w, input int k);
        word[src]    = w;
        abort_k[src] = k;
        exp_src.push_back(src);
        exp_a.push_back(k >= 0);
        exp_m.push_back((k < 0) && has_baz(w));
        exp_s.push_back((k < 0) ? w : w.substr(0, k - 1));
    endtask

    task automatic drive_all();
        int pos[NUM_SRC];
        int gap[NUM_SRC];
        bit done[NUM_SRC];
        logic [NUM_SRC-1:0]   v, l, hs;
        logic [8*NUM_SRC-1:0] c;
        string ws;
        int budget;
        bit all_done;
        for (int i = 0; i < NUM_SRC; i++) begin
            pos[i]  = 0;
            gap[i]  = $urandom_range(0, gap_max);
            done[i] = (word[i].len() == 0);
        end
        budget = 0;
        @(posedge clk); #1;
        while (1) begin
            all_done = 1'b1;
            for (int i = 0; i < NUM_SRC; i++) if (!done[i]) all_done = 1'b0;
            if (all_done) break;
            if (budget >= 5000) begin
                fail_bound("drive_all");
                break;
            end
            v = '0; l = '0; c = '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!done[i] && gap[i] == 0) begin
                    ws = word[i];
                    v[i] = 1'b1;
                    c[8*i +: 8] = ws[pos[i]];
                    l[i] = (abort_k[i] < 0) && (pos[i] == ws.len() - 1);
                end
            end
            bif.req_valid = v; bif.req_char = c; bif.req_last = l;
            @(negedge clk);
            hs = bif.req_valid & bif.req_ready;
            @(posedge clk); #1;
            budget++;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (hs[i]) begin
                    pos[i]++;
                    gap[i] = $urandom_range(0, gap_max);
                    if ((abort_k[i] >= 0 && pos[i] >= abort_k[i]) || pos[i] >= word[i].len()) done[i] = 1'b1;
                end else if (!v[i] && gap[i] > 0) begin
                    gap[i]--;
                end
            end
        end
        bif.req_valid = '0;
        bif.req_last  = '0;
        for (int i = 0; i < NUM_SRC; i++) word[i] = "";
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_src.size() != 0 || bif.busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_bound("wait_idle");
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_busy"},       bif.busy,       0);
        check({tag, "_det_valid"},  bif.det_valid,  0);
        check({tag, "_det_clr"},    bif.det_clr,    0);
        check({tag, "_det_char"},   bif.det_char,   0);
        check({tag, "_resp_valid"}, bif.resp_valid, 0);
        check({tag, "_resp_match"}, bif.resp_match, 0);
        check({tag, "_resp_abort"}, bif.resp_abort, 0);
        check({tag, "_grant_id"},   bif.grant_id,   0);
        check({tag, "_req_ready"},  bif.req_ready,  0);
    endtask

    // Monitor: compares every response strobe against the oldest pending word of that source.
    int  cyc = 0;
    int  last_hs_cyc = 0;
    bit  clr_pending = 1'b0;
    byte unsigned cur_q[$];
    int  m_src, m_idx;
    string m_es;

    always @(negedge clk) begin
        if (rstn) begin
            cur_q.delete();
            clr_pending = 1'b0;
        end else begin
            if (clr_pending || bif.det_clr) begin
                check("det_clr_after_resp", bif.det_clr, clr_pending);
                clr_pending = 1'b0;
            end
            if (bif.req_ready != '0)
                check("ready_onehot_valid",
                      ($countones(bif.req_ready) == 1) && ((bif.req_ready & ~bif.req_valid) == '0), 1);
            if (bif.det_valid) cur_q.push_back(bif.det_char);
            if ((bif.req_ready & bif.req_valid) != '0) last_hs_cyc = cyc;
            if (bif.resp_valid != '0) begin
                check("resp_onehot", $countones(bif.resp_valid), 1);
                m_src = 0;
                for (int i = 0; i < NUM_SRC; i++) if (bif.resp_valid[i]) m_src = i;
                m_idx = -1;
                for (int j = 0; j < exp_src.size(); j++) if (m_idx < 0 && exp_src[j] == m_src) m_idx = j;
                if (m_idx < 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_resp: source %0d strobed, no word pending", m_src);
                end else begin
                    m_es = exp_s[m_idx];
                    check("resp_match", bif.resp_match, exp_m[m_idx]);
                    check("resp_abort", bif.resp_abort, exp_a[m_idx]);
                    check("grant_id",   bif.grant_id,   m_src);
                    check("det_char_count", cur_q.size(), m_es.len());
                    for (int j = 0; j < cur_q.size() && j < m_es.len(); j++)
                        check("det_char", cur_q[j], m_es[j]);
                    if (exp_a[m_idx]) check("abort_latency", cyc - last_hs_cyc, TIMEOUT + 1);
                    else              check("resp_latency",  cyc - last_hs_cyc, DET_LAT + 2);
                    exp_src.delete(m_idx);
                    exp_m.delete(m_idx);
                    exp_a.delete(m_idx);
                    exp_s.delete(m_idx);
                end
                if (exp_order.size() > 0) begin
                    check("rr_order", m_src, exp_order[0]);
                    void'(exp_order.pop_front());
                end
                clr_pending = 1'b1;
                cur_q.delete();
            end
        end
        cyc++;
    end

    // Watchdog so the run always terminates
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    int n;
    int mask;
    int k;
    string w;

    initial begin
        rstn          = 1'b1;
        bif.req_valid = '0;
        bif.req_char  = '0;
        bif.req_last  = '0;
        gap_max       = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            word[i]    = "";
            abort_k[i] = -1;
        end

        // 1: reset
        repeat (3) @(posedge clk);
        #1;
        chk_zero("in_reset");
        rstn = 1'b0;
        @(negedge clk);
        chk_zero("after_reset");

        // 2: BAZ match from src0
        issue(0, "BAZ", -1);
        drive_all(); wait_idle();

        // 3: no match
        issue(0, "BANKM", -1);
        drive_all(); wait_idle();

        // single-character word
        issue(0, "Z", -1);
        drive_all(); wait_idle();

        // 4: round-robin ordering
        exp_order.push_back(1); exp_order.push_back(2);
        issue(1, "XBAZ", -1); issue(2, "AB", -1);
        drive_all(); wait_idle();
        exp_order.push_back(3); exp_order.push_back(1);
        issue(3, "BAZBAZ", -1); issue(1, "K", -1);
        drive_all(); wait_idle();
        check("rr_order_drained", exp_order.size(), 0);

        // 5: timeout abort after one character
        issue(2, "BAZ", 1);
        drive_all(); wait_idle();

        // 6: reset in the middle of a word
        bif.req_char  = 32'h0000_0042;
        bif.req_last  = 4'b0000;
        bif.req_valid = 4'b0001;
        n = 0;
        @(negedge clk);
        while (!bif.req_ready[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_bound("mid_word_grant");
        @(posedge clk); #1;
        bif.req_valid = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_busy", bif.busy, 1);
        check("pre_reset_det_char", bif.det_char, 8'h42);
        rstn = 1'b1;
        #1;
        chk_zero("mid_word_reset");
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
        // rr pointer back at 0: src0 must win over src3
        exp_order.push_back(0); exp_order.push_back(3);
        issue(0, "BAZ", -1); issue(3, "NAB", -1);
        drive_all(); wait_idle();

        // random rounds
        gap_max = 3;
        for (int r = 0; r < 30; r++) begin
            mask = $urandom_range(1, (1 << NUM_SRC) - 1);
            for (int i = 0; i < NUM_SRC; i++) begin
                if (((mask >> i) & 1) == 1) begin
                    w = rand_word();
                    k = -1;
                    if ($urandom_range(0, 11) == 0) k = $urandom_range(1, w.len());
                    issue(i, w, k);
                end
            end
            drive_all();
            wait_idle();
        end
        check("scoreboard_drained", exp_src.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
